dp5_fire_sequencer: RTL and testbench
=====================================

Name: dp5_fire_sequencer

Overview:
- Upstream stage of the 5-philosopher synchronous Mealy MSFSM block; drives its transition inputs t0..t9.
- Holds the reference Petri-net marking for the dining-philosophers model.
- Accepts level-sensitive firing requests and arbitrates among enabled transitions with a round-robin pointer.
- Emits registered one-cycle fire pulses t0..t9, so the downstream FSMs only ever see legal interleavings.

Parameters:
- STARVE_LIMIT, 15: cycles a pending take request may go ungranted before its starve flag asserts; range 1..255.
- CNT_W, 8: width of the per-philosopher wait counters; must satisfy 2^CNT_W-1 >= STARVE_LIMIT.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high
- req  input  10  req[k] requests firing of transition tk; level, held by the source
- t0..t9  output  1 each  registered fire pulses to the MSFSM block
- think  output  5  think[i] is 1 when philosopher i is in the thinking place
- eat  output  5  eat[i] is 1 when philosopher i is in the eating place
- fork_free  output  5  fork_free[j] is 1 when fork j is available
- enabled  output  10  combinational enabling vector of the current marking
- starve  output  5  starve[i] is 1 when philosopher i's take request has waited at least STARVE_LIMIT cycles
- illegal  output  1  sticky; set when a request targets a disabled transition

Behaviour:
- Net structure, philosopher i = 0..4, right fork r = (i+1) mod 5:
  - take_i = t(2i): needs think[i], fork_free[i] and fork_free[r]; clears those three; sets eat[i].
  - release_i = t(2i+1): needs eat[i]; clears eat[i]; sets think[i], fork_free[i] and fork_free[r].
- Reset (synchronous, active-high), on the first clk edge with reset=1:
  - think=5'h1F, eat=0, fork_free=5'h1F.
  - All t outputs 0, round-robin pointer 0, wait counters 0, starve=0, illegal=0.
  - Reset mid-operation aborts the current fire; the cycle after reset deasserts has t=0.
- Candidates: cand = req & enabled.
- Grant, default build: at most one transition fires per clock.
  - The winner is the first set bit of cand scanning upward from pointer k_ptr, with wrap-around 9 -> 0.
- Registered result at the edge ending cycle n:
  - the winner's t pulse is 1 for exactly cycle n+1;
  - the marking is updated at that same edge, so t and the new marking are visible together;
  - k_ptr becomes (winner+1) mod 10.
- cand == 0: no pulse, marking and pointer unchanged.
- A request held high refires every cycle while it stays enabled. After take_i fires, take_i is disabled until release_i fires.
- Requested but disabled transition (req & ~enabled != 0): illegal goes to 1 on the next edge and stays 1 until reset; the request has no other effect.
- Wait counter i:
  - increments each cycle req[2i]=1 and take_i is not granted; saturates at 2^CNT_W-1;
  - clears on a take_i grant or when req[2i]=0.
  - starve[i] = (counter >= STARVE_LIMIT), registered.
- Invariants, asserted in simulation:
  - think[i] xor eat[i] = 1 for every i;
  - no two adjacent philosophers eat at once;
  - the t vector is one-hot or zero in the default build.

Optional Feature:
- Macro: DP5_MULTI_FIRE_EN.
- Defined: a maximal conflict-free set fires per cycle.
  - Scan from k_ptr in wrap order.
  - Grant each candidate whose input places (forks/think/eat) have not already been consumed by an earlier grant in the same scan.
  - All granted t pulses assert together; the marking applies the combined update.
  - k_ptr becomes (last granted index + 1) mod 10.
  - The one-hot assertion is replaced by a no-shared-fork check.
- Undefined: single-fire behaviour as above.

Test Plan:
- Reset then req=10'h001 for 1 cycle:
  - t0=1 in the cycle after the request, then 0;
  - eat=5'h01, fork_free=5'h1C, think=5'h1E.
- After the first scenario, req=10'h004 (take_1 needs fork 1, which is taken):
  - no t pulse; illegal=1 on the next cycle and remains 1.
- Reset, then req=10'h005 held, default build:
  - t0 fires first (pointer 0);
  - take_1 is then disabled while philosopher 0 eats, so the request is illegal and illegal=1.
- Reset, take_0, then req=10'h002:
  - t1 pulse follows;
  - marking returns to think=5'h1F, fork_free=5'h1F.
- Reset, STARVE_LIMIT=15, hold req[0] and req[2]:
  - philosopher 0 eats;
  - philosopher 1's counter reaches 15, so starve[1]=1 on cycle 16;
  - after releasing philosopher 0, take_1 fires and starve[1] returns to 0 the next cycle.
- DP5_MULTI_FIRE_EN, reset, req=10'h015 (take_0, take_1, take_2):
  - t0 and t4 pulse in the same cycle; t2 does not pulse;
  - eat=5'h05, fork_free=5'h10.

Source files
------------

// File: rtl/dp5_fire_sequencer.sv
`default_nettype none
// ============================================================================
// dp5_fire_sequencer : round-robin Petri-net fire sequencer for 5 dining
// philosophers. Optional macro DP5_MULTI_FIRE_EN fires a conflict-free set.
// Revision: 1.0
// ============================================================================
module dp5_fire_sequencer #(
    parameter int STARVE_LIMIT = 15,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] req,
    output logic       t0,
    output logic       t1,
    output logic       t2,
    output logic       t3,
    output logic       t4,
    output logic       t5,
    output logic       t6,
    output logic       t7,
    output logic       t8,
    output logic       t9,
    output logic [4:0] think,
    output logic [4:0] eat,
    output logic [4:0] fork_free,
    output logic [9:0] enabled,
    output logic [4:0] starve,
    output logic       illegal
);
    logic [4:0]       r_think;
    logic [4:0]       r_eat;
    logic [4:0]       r_fork;
    logic [9:0]       r_t;
    logic [3:0]       r_ptr;
    logic [4:0]       r_starve;
    logic             r_illegal;
    logic [CNT_W-1:0] r_cnt [5];

    logic [9:0]       w_en;
    logic [9:0]       w_cand;
    logic [9:0]       w_grant;
    logic             w_any;
    logic [3:0]       w_last;
    logic [3:0]       w_ptr_next;
    logic [4:0]       w_think_next;
    logic [4:0]       w_eat_next;
    logic [4:0]       w_fork_next;
    logic [CNT_W-1:0] w_cnt_next [5];
    logic [4:0]       w_starve_next;

    // Even transitions are takes, odd transitions are releases.
    always_comb begin
        w_en = '0;
        for (int i = 0; i < 5; i++) begin
            w_en[2*i]   = r_think[i] & r_fork[i] & r_fork[(i+1)%5];
            w_en[2*i+1] = r_eat[i];
        end
    end

    assign w_cand = req & w_en;

    always_comb begin
        int idx;
        int p;
        int rr;
`ifdef DP5_MULTI_FIRE_EN
        logic [4:0] think_av;
        logic [4:0] eat_av;
        logic [4:0] fork_av;
        think_av = r_think;
        eat_av   = r_eat;
        fork_av  = r_fork;
`endif
        w_grant = '0;
        w_any   = 1'b0;
        w_last  = r_ptr;
        for (int off = 0; off < 10; off++) begin
            idx = (int'(r_ptr) + off) % 10;
            p   = idx / 2;
            rr  = (p + 1) % 5;
`ifdef DP5_MULTI_FIRE_EN
            // Tokens consumed by an earlier grant in this scan block later ones.
            if (w_cand[idx]) begin
                if (idx % 2 == 0) begin
                    if (think_av[p] && fork_av[p] && fork_av[rr]) begin
                        w_grant[idx] = 1'b1;
                        think_av[p]  = 1'b0;
                        fork_av[p]   = 1'b0;
                        fork_av[rr]  = 1'b0;
                        w_any        = 1'b1;
                        w_last       = 4'(idx);
                    end
                end else if (eat_av[p]) begin
                    w_grant[idx] = 1'b1;
                    eat_av[p]    = 1'b0;
                    w_any        = 1'b1;
                    w_last       = 4'(idx);
                end
            end
`else
            if (w_cand[idx] && !w_any) begin
                w_grant[idx] = 1'b1;
                w_any        = 1'b1;
                w_last       = 4'(idx);
            end
`endif
        end
    end

    assign w_ptr_next = !w_any ? r_ptr : ((w_last == 4'd9) ? 4'd0 : w_last + 4'd1);

    always_comb begin
        w_think_next = r_think;
        w_eat_next   = r_eat;
        w_fork_next  = r_fork;
        for (int i = 0; i < 5; i++) begin
            if (w_grant[2*i+1]) begin
                w_eat_next[i]         = 1'b0;
                w_think_next[i]       = 1'b1;
                w_fork_next[i]        = 1'b1;
                w_fork_next[(i+1)%5]  = 1'b1;
            end
            if (w_grant[2*i]) begin
                w_think_next[i]       = 1'b0;
                w_eat_next[i]         = 1'b1;
                w_fork_next[i]        = 1'b0;
                w_fork_next[(i+1)%5]  = 1'b0;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            if (!req[2*i] || w_grant[2*i])
                w_cnt_next[i] = '0;
            else if (r_cnt[i] == '1)
                w_cnt_next[i] = r_cnt[i];
            else
                w_cnt_next[i] = r_cnt[i] + 1'b1;
            w_starve_next[i] = (w_cnt_next[i] >= CNT_W'(STARVE_LIMIT));
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_think   <= 5'h1F;
            r_eat     <= 5'h00;
            r_fork    <= 5'h1F;
            r_t       <= '0;
            r_ptr     <= '0;
            r_starve  <= '0;
            r_illegal <= 1'b0;
            for (int i = 0; i < 5; i++) r_cnt[i] <= '0;
        end else begin
            r_think   <= w_think_next;
            r_eat     <= w_eat_next;
            r_fork    <= w_fork_next;
            r_t       <= w_grant;
            r_ptr     <= w_ptr_next;
            r_starve  <= w_starve_next;
            r_illegal <= r_illegal | (|(req & ~w_en));
            for (int i = 0; i < 5; i++) r_cnt[i] <= w_cnt_next[i];
        end
    end

    assign {t9, t8, t7, t6, t5, t4, t3, t2, t1, t0} = r_t;
    assign think     = r_think;
    assign eat       = r_eat;
    assign fork_free = r_fork;
    assign enabled   = w_en;
    assign starve    = r_starve;
    assign illegal   = r_illegal;

    a_think_xor_eat: assert property (@(posedge clk) disable iff (reset)
        (r_think ^ r_eat) == 5'h1F);
    a_no_adjacent_eat: assert property (@(posedge clk) disable iff (reset)
        (r_eat & {r_eat[0], r_eat[4:1]}) == 5'h00);
`ifdef DP5_MULTI_FIRE_EN
    logic [4:0] w_take;
    assign w_take = {r_t[8], r_t[6], r_t[4], r_t[2], r_t[0]};
    a_no_shared_fork: assert property (@(posedge clk) disable iff (reset)
        (w_take & {w_take[0], w_take[4:1]}) == 5'h00);
`else
    a_onehot_fire: assert property (@(posedge clk) disable iff (reset)
        $onehot0(r_t));
`endif

endmodule
`default_nettype wire

// File: tb/tb_dp5_fire_sequencer.sv
`default_nettype none
// Randomized and directed bench for dp5_fire_sequencer against a
// philosopher-level reference model.
module tb_dp5_fire_sequencer;
    localparam int LIMIT = 15;
    localparam int CMAX  = 255;

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [9:0] req   = '0;
    logic t0, t1, t2, t3, t4, t5, t6, t7, t8, t9;
    logic [4:0] think, eat, fork_free, starve;
    logic [9:0] enabled;
    logic       illegal;
    logic [9:0] dut_t;

    dp5_fire_sequencer #(.STARVE_LIMIT(LIMIT), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .req(req),
        .t0(t0), .t1(t1), .t2(t2), .t3(t3), .t4(t4),
        .t5(t5), .t6(t6), .t7(t7), .t8(t8), .t9(t9),
        .think(think), .eat(eat), .fork_free(fork_free),
        .enabled(enabled), .starve(starve), .illegal(illegal)
    );

    always #5 clk = ~clk;
    assign dut_t = {t9, t8, t7, t6, t5, t4, t3, t2, t1, t0};

    int n_tests = 0;
    int n_fail  = 0;

    // Model state: which philosophers eat; forks and think are derived.
    logic [4:0] m_eat;
    int         m_ptr;
    logic [9:0] m_t;
    int         m_cnt [5];
    logic [4:0] m_starve;
    logic       m_illegal;

    function automatic logic [4:0] m_forks();
        logic [4:0] f;
        f = '0;
        for (int j = 0; j < 5; j++) f[j] = !m_eat[j] && !m_eat[(j+4)%5];
        return f;
    endfunction

    function automatic logic [9:0] m_enabled();
        logic [9:0] e;
        e = '0;
        for (int i = 0; i < 5; i++) begin
            e[2*i]   = !m_eat[(i+4)%5] && !m_eat[i] && !m_eat[(i+1)%5];
            e[2*i+1] = m_eat[i];
        end
        return e;
    endfunction

    task automatic model_reset();
        m_eat = '0; m_ptr = 0; m_t = '0; m_starve = '0; m_illegal = 1'b0;
        for (int i = 0; i < 5; i++) m_cnt[i] = 0;
    endtask

    task automatic model_step(input logic [9:0] r);
        logic [9:0] en, cand, grant;
        int k, p, last;
        bit any;
        en = m_enabled();
        cand = r & en;
        grant = '0;
        any = 0;
        last = 0;
        if ((r & ~en) != 0) m_illegal = 1'b1;
        for (int off = 0; off < 10; off++) begin
            k = (m_ptr + off) % 10;
            p = k / 2;
            if (cand[k]) begin
`ifdef DP5_MULTI_FIRE_EN
                if (k % 2 == 1 || !(grant[2*((p+4)%5)] || grant[2*((p+1)%5)])) begin
                    grant[k] = 1'b1; last = k; any = 1;
                end
`else
                if (!any) begin grant[k] = 1'b1; last = k; any = 1; end
`endif
            end
        end
        if (any) m_ptr = (last + 1) % 10;
        for (int i = 0; i < 5; i++) begin
            if (grant[2*i])   m_eat[i] = 1'b1;
            if (grant[2*i+1]) m_eat[i] = 1'b0;
            if (!r[2*i] || grant[2*i]) m_cnt[i] = 0;
            else if (m_cnt[i] < CMAX) m_cnt[i]++;
            m_starve[i] = (m_cnt[i] >= LIMIT);
        end
        m_t = grant;
    endtask

    task automatic tick(input logic [9:0] r);
        req = r;
        model_step(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [9:0] r);
        req = r;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        do_reset(10'h000);
        tick(10'h001);
        do_reset(10'h3FF);
        n_tests++; if (dut_t !== 10'h000) begin n_fail++; $display("FAIL reset_t got=%h exp=%h", dut_t, 10'h000); end
        n_tests++; if ({think, eat, fork_free} !== {5'h1F, 5'h00, 5'h1F}) begin n_fail++; $display("FAIL reset_marking got=%h exp=%h", {think, eat, fork_free}, {5'h1F, 5'h00, 5'h1F}); end
        n_tests++; if ({starve, illegal} !== 6'h00) begin n_fail++; $display("FAIL reset_flags got=%h exp=%h", {starve, illegal}, 6'h00); end
        n_tests++; if (enabled !== 10'h155) begin n_fail++; $display("FAIL reset_enabled got=%h exp=%h", enabled, 10'h155); end
        req = '0;
    endtask

    task automatic test_take_then_illegal();
        do_reset(10'h000);
        tick(10'h001);
        n_tests++; if (dut_t !== 10'h001) begin n_fail++; $display("FAIL take0_t got=%h exp=%h", dut_t, 10'h001); end
        n_tests++; if ({eat, fork_free, think} !== {5'h01, 5'h1C, 5'h1E}) begin n_fail++; $display("FAIL take0_marking got=%h exp=%h", {eat, fork_free, think}, {5'h01, 5'h1C, 5'h1E}); end
        tick(10'h000);
        n_tests++; if (dut_t !== 10'h000) begin n_fail++; $display("FAIL take0_pulse_end got=%h exp=%h", dut_t, 10'h000); end
        tick(10'h004);
        n_tests++; if ({dut_t, illegal} !== {10'h000, 1'b1}) begin n_fail++; $display("FAIL illegal_set got=%h exp=%h", {dut_t, illegal}, {10'h000, 1'b1}); end
        tick(10'h000);
        n_tests++; if ({illegal, eat} !== {1'b1, 5'h01}) begin n_fail++; $display("FAIL illegal_sticky got=%h exp=%h", {illegal, eat}, {1'b1, 5'h01}); end
    endtask

    task automatic test_both_held();
        do_reset(10'h000);
        tick(10'h005);
        n_tests++; if ({dut_t, illegal} !== {10'h001, 1'b0}) begin n_fail++; $display("FAIL both_first got=%h exp=%h", {dut_t, illegal}, {10'h001, 1'b0}); end
        tick(10'h005);
        n_tests++; if ({dut_t, illegal, eat} !== {10'h000, 1'b1, 5'h01}) begin n_fail++; $display("FAIL both_second got=%h exp=%h", {dut_t, illegal, eat}, {10'h000, 1'b1, 5'h01}); end
    endtask

    task automatic test_release();
        do_reset(10'h000);
        tick(10'h001);
        tick(10'h002);
        n_tests++; if (dut_t !== 10'h002) begin n_fail++; $display("FAIL release_t got=%h exp=%h", dut_t, 10'h002); end
        n_tests++; if ({think, fork_free, eat} !== {5'h1F, 5'h1F, 5'h00}) begin n_fail++; $display("FAIL release_marking got=%h exp=%h", {think, fork_free, eat}, {5'h1F, 5'h1F, 5'h00}); end
    endtask

    task automatic test_round_robin();
        do_reset(10'h000);
        tick(10'h001);
        tick(10'h002);
        tick(10'h041);
        n_tests++; if (dut_t !== 10'h040) begin n_fail++; $display("FAIL rr_from_ptr2 got=%h exp=%h", dut_t, 10'h040); end
        tick(10'h001);
        n_tests++; if ({dut_t, eat} !== {10'h001, 5'h09}) begin n_fail++; $display("FAIL rr_wrap got=%h exp=%h", {dut_t, eat}, {10'h001, 5'h09}); end
    endtask

    task automatic test_starve();
        do_reset(10'h000);
        for (int c = 1; c <= 15; c++) begin
            tick(10'h005);
            if (c == 14) begin
                n_tests++; if (starve !== 5'h00) begin n_fail++; $display("FAIL starve_c14 got=%h exp=%h", starve, 5'h00); end
            end
        end
        n_tests++; if (starve !== 5'h02) begin n_fail++; $display("FAIL starve_c15 got=%h exp=%h", starve, 5'h02); end
        tick(10'h006);
        n_tests++; if ({dut_t, starve} !== {10'h002, 5'h02}) begin n_fail++; $display("FAIL starve_release got=%h exp=%h", {dut_t, starve}, {10'h002, 5'h02}); end
        tick(10'h004);
        n_tests++; if ({dut_t, starve, eat} !== {10'h004, 5'h00, 5'h02}) begin n_fail++; $display("FAIL starve_clear got=%h exp=%h", {dut_t, starve, eat}, {10'h004, 5'h00, 5'h02}); end
    endtask

    task automatic test_multi_request();
        do_reset(10'h000);
        tick(10'h015);
`ifdef DP5_MULTI_FIRE_EN
        n_tests++; if ({dut_t, eat, fork_free} !== {10'h011, 5'h05, 5'h10}) begin n_fail++; $display("FAIL multi_fire got=%h exp=%h", {dut_t, eat, fork_free}, {10'h011, 5'h05, 5'h10}); end
`else
        n_tests++; if ({dut_t, eat, fork_free} !== {10'h001, 5'h01, 5'h1C}) begin n_fail++; $display("FAIL single_fire got=%h exp=%h", {dut_t, eat, fork_free}, {10'h001, 5'h01, 5'h1C}); end
`endif
    endtask

    task automatic test_random();
        logic [9:0] r;
        logic [40:0] got, exp;
        do_reset(10'h000);
        for (int n = 0; n < 500; n++) begin
            if (n % 97 == 96) do_reset(10'($urandom));
            r = 10'($urandom);
            if ($urandom_range(7, 0) != 0) r = r & m_enabled();
            tick(r);
            got = {dut_t, think, eat, fork_free, enabled, starve, illegal};
            exp = {m_t, ~m_eat, m_eat, m_forks(), m_enabled(), m_starve, m_illegal};
            n_tests++;
            if (got !== exp) begin
                n_fail++;
                $display("FAIL random_cycle%0d req=%h got=%h exp=%h", n, r, got, exp);
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        test_reset();
        test_take_then_illegal();
        test_both_held();
        test_release();
        test_round_robin();
        test_starve();
        test_multi_request();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
